i2c_uart_cmd_bridge: RTL and testbench
======================================

// Module: i2c_uart_cmd_bridge
// PURPOSE
//  Upstream command stage for i2c_control. Parses framed register-access commands from
//  the UART receiver, issues one wrreg_req/rdreg_req pulse to i2c_control, waits for
//  RW_Done, then returns a status byte (plus read data) to the UART transmitter.
//  Lets a host PC read/write EEPROM or I2C peripheral registers over the serial link.
// PARAMETERS
//  HEADER        8'h55     frame start byte
//  BYTE_TIMEOUT  500000    max Clk cycles between frame bytes (10 ms at 50 MHz)
//  I2C_TIMEOUT   5000000   max Clk cycles from request pulse to RW_Done (100 ms)
// PORTS
//  Clk        in   1   system clock, all logic on posedge
//  Rst        in   1   asynchronous reset, active-high
//  rx_data    in   8   received UART byte, valid when rx_done=1
//  rx_done    in   1   1-cycle pulse per received byte
//  tx_data    out  8   byte to transmit, stable from tx_start until tx_done
//  tx_start   out  1   1-cycle pulse: start sending tx_data
//  tx_done    in   1   1-cycle pulse from UART tx: byte finished
//  wrreg_req  out  1   1-cycle write request to i2c_control
//  rdreg_req  out  1   1-cycle read request to i2c_control
//  addr       out  16  register address, held stable until RW_Done
//  addr_mode  out  1   0 = 8-bit address (addr[7:0]), 1 = 16-bit address
//  wrdata     out  8   write data, held stable until RW_Done
//  device_id  out  8   I2C device ID byte (write form, e.g. 8'hA0)
//  RW_Done    in   1   1-cycle pulse from i2c_control: transaction complete
//  ack        in   1   sampled at RW_Done: 1 = NACK/failure, 0 = success
//  rddata     in   8   read data from i2c_control, sampled at RW_Done
//  busy       out  1   high from first byte after HEADER until last response byte tx_done
// BEHAVIOUR
//  Frame: HEADER, OP, DEV, ADDR_H, ADDR_L, [DATA if write]. OP[0]=1 read, OP[1]=addr_mode,
//   OP[7:2] must be 0. ADDR_H always sent; ignored by i2c_control when addr_mode=0.
//  States: IDLE -> GET_OP -> GET_DEV -> GET_AH -> GET_AL -> (write: GET_DATA) -> ISSUE
//   -> WAIT_DONE -> TX_STAT -> (read success: TX_DATA) -> IDLE. Error path: TX_ERR -> IDLE.
//  IDLE: rx_done with rx_data!=HEADER ignored; HEADER -> GET_OP.
//  GET_OP: OP[7:2]!=0 -> TX_ERR, response 8'hE1, no I2C request.
//  Latency: rx_done of final frame byte at cycle N -> req pulse at N+1 (one pulse, width 1).
//  addr/addr_mode/device_id/wrdata registered on byte capture; unchanged until next ISSUE.
//  WAIT_DONE: RW_Done with ack=0 -> status 8'hA5; ack=1 -> 8'hEE (no data byte);
//   rddata latched on RW_Done. tx_start pulses cycle after RW_Done.
//  I2C timeout: I2C_TIMEOUT cycles in WAIT_DONE without RW_Done -> status 8'hEF, IDLE after tx.
//  Byte timeout: counter cleared on every rx_done in GET_*; reaching BYTE_TIMEOUT -> IDLE
//   silently, no request, no response.
//  TX_STAT/TX_DATA: one tx_start pulse each, next step only on tx_done. TX_DATA sends rddata.
//  rx_done while in ISSUE/WAIT_DONE/TX_*: byte discarded, no effect.
//  RW_Done outside WAIT_DONE: ignored. RW_Done and timeout same cycle: RW_Done wins.
//  Reset (any state, incl. mid-transaction): state IDLE, all outputs 0 (tx_data, addr,
//   wrdata, device_id = 0; req/tx_start/busy = 0), counters cleared.
//  Counters sized $clog2(param+1); no wrap (saturate at terminal value then leave state).
// TESTING
//  55 00 A0 00 0A D1 -> one wrreg_req pulse, addr=16'h000A, addr_mode=0, device_id=A0,
//   wrdata=D1; model RW_Done ack=0 -> tx A5 only, busy falls after tx_done.
//  55 01 A0 00 0B, RW_Done ack=0 rddata=D2 -> one rdreg_req; tx A5 then D2.
//  55 03 A0 12 34, RW_Done ack=1 -> rdreg_req, addr=16'h1234, addr_mode=1; tx EE only.
//  55 07 -> tx E1, no wrreg_req/rdreg_req; following valid write frame executes normally.
//  55 00 A0 then silence BYTE_TIMEOUT+10 cycles -> no req, no tx, busy=0; 55 00 A0 00 0C D3
//   then succeeds. No RW_Done after req for I2C_TIMEOUT -> tx EF.
//  Assert Rst during WAIT_DONE -> all outputs 0 immediately; extra rx bytes during
//   WAIT_DONE produce no second request.

Source files
------------

// File: rtl/i2c_uart_cmd_bridge.sv
// i2c_uart_cmd_bridge
//   Upstream command stage for i2c_control. Parses framed register-access
//   commands arriving from a UART receiver, fires a single wrreg_req or
//   rdreg_req pulse, waits for RW_Done, and returns a status byte (plus the
//   read data on a successful read) through the UART transmitter.
//
//   Frame: HEADER, OP, DEV, ADDR_H, ADDR_L, [DATA if write]
//     OP[0] = 1 read / 0 write, OP[1] = addr_mode, OP[7:2] must be zero.
//   Responses: A5 success, EE NACK, EF I2C timeout, E1 bad opcode.
//
// Ports
//   Clk, Rst                 clock, asynchronous active-high reset
//   rx_data, rx_done         received UART byte and its 1-cycle strobe
//   tx_data, tx_start        byte to send and its 1-cycle start strobe
//   tx_done                  1-cycle strobe: transmitter finished a byte
//   wrreg_req, rdreg_req     1-cycle request pulses to i2c_control
//   addr, addr_mode          register address and 8/16-bit mode
//   wrdata, device_id        write data and I2C device ID (write form)
//   RW_Done, ack, rddata     completion strobe, NACK flag, read data
//   busy                     high while a command frame is in progress
module i2c_uart_cmd_bridge #(
  parameter logic [7:0]  HEADER       = 8'h55,
  parameter int unsigned BYTE_TIMEOUT = 500000,
  parameter int unsigned I2C_TIMEOUT  = 5000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        wrreg_req,
  output logic        rdreg_req,
  output logic [15:0] addr,
  output logic        addr_mode,
  output logic [7:0]  wrdata,
  output logic [7:0]  device_id,
  input  logic        RW_Done,
  input  logic        ack,
  input  logic [7:0]  rddata,
  output logic        busy
);

  localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned IW = $clog2(I2C_TIMEOUT + 1);
  localparam logic [BW-1:0] BYTE_LIMIT = BW'(BYTE_TIMEOUT);
  localparam logic [IW-1:0] I2C_LIMIT  = IW'(I2C_TIMEOUT);

  localparam logic [7:0] ST_OK     = 8'hA5;
  localparam logic [7:0] ST_NACK   = 8'hEE;
  localparam logic [7:0] ST_TMO    = 8'hEF;
  localparam logic [7:0] ST_BAD_OP = 8'hE1;

  typedef enum logic [3:0] {
    IDLE,
    GET_OP,
    GET_DEV,
    GET_AH,
    GET_AL,
    GET_DATA,
    ISSUE,
    WAIT_DONE,
    TX_STAT,
    TX_DATA,
    TX_ERR
  } state_t;

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [IW-1:0] i2c_cnt;

  // Frame fields are collected into shadow registers and only copied to the
  // outputs together with the request pulse, so an aborted or rejected frame
  // never disturbs the address/data presented to i2c_control.
  logic          op_rd;
  logic          op_mode;
  logic [7:0]    dev_s;
  logic [7:0]    ah_s;
  logic [7:0]    al_s;
  logic [7:0]    rddata_q;
  logic          send_data;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      i2c_cnt   <= '0;
      op_rd     <= 1'b0;
      op_mode   <= 1'b0;
      dev_s     <= '0;
      ah_s      <= '0;
      al_s      <= '0;
      rddata_q  <= '0;
      send_data <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      wrreg_req <= 1'b0;
      rdreg_req <= 1'b0;
      addr      <= '0;
      addr_mode <= 1'b0;
      wrdata    <= '0;
      device_id <= '0;
      busy      <= 1'b0;
    end else begin
      wrreg_req <= 1'b0;
      rdreg_req <= 1'b0;
      tx_start  <= 1'b0;

      case (state)
        IDLE: begin
          byte_cnt <= '0;
          i2c_cnt  <= '0;
          if (rx_done && (rx_data == HEADER)) begin
            state <= GET_OP;
            busy  <= 1'b1;
          end
        end

        GET_OP, GET_DEV, GET_AH, GET_AL, GET_DATA: begin
          if (rx_done) begin
            byte_cnt <= '0;
            case (state)
              GET_OP: begin
                if (rx_data[7:2] != '0) begin
                  tx_data  <= ST_BAD_OP;
                  tx_start <= 1'b1;
                  state    <= TX_ERR;
                end else begin
                  op_rd   <= rx_data[0];
                  op_mode <= rx_data[1];
                  state   <= GET_DEV;
                end
              end
              GET_DEV: begin
                dev_s <= rx_data;
                state <= GET_AH;
              end
              GET_AH: begin
                ah_s  <= rx_data;
                state <= GET_AL;
              end
              GET_AL: begin
                if (op_rd) begin
                  addr      <= {ah_s, rx_data};
                  addr_mode <= op_mode;
                  device_id <= dev_s;
                  rdreg_req <= 1'b1;
                  state     <= ISSUE;
                end else begin
                  al_s  <= rx_data;
                  state <= GET_DATA;
                end
              end
              default: begin
                addr      <= {ah_s, al_s};
                addr_mode <= op_mode;
                device_id <= dev_s;
                wrdata    <= rx_data;
                wrreg_req <= 1'b1;
                state     <= ISSUE;
              end
            endcase
          end else if (byte_cnt == BYTE_LIMIT) begin
            // Host went quiet mid-frame: drop it without any response.
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= '0;
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end

        // The request pulse is already on the wires during this cycle.
        ISSUE: begin
          i2c_cnt <= '0;
          state   <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (RW_Done) begin
            rddata_q <= rddata;
            tx_start <= 1'b1;
            state    <= TX_STAT;
            if (ack) begin
              tx_data   <= ST_NACK;
              send_data <= 1'b0;
            end else begin
              tx_data   <= ST_OK;
              send_data <= op_rd;
            end
          end else if (i2c_cnt == I2C_LIMIT) begin
            tx_data   <= ST_TMO;
            send_data <= 1'b0;
            tx_start  <= 1'b1;
            state     <= TX_STAT;
          end else begin
            i2c_cnt <= i2c_cnt + IW'(1);
          end
        end

        TX_STAT: begin
          if (tx_done) begin
            if (send_data) begin
              tx_data  <= rddata_q;
              tx_start <= 1'b1;
              state    <= TX_DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        TX_DATA, TX_ERR: begin
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_uart_cmd_bridge.sv
// tb_i2c_uart_cmd_bridge
//   Directed bench for i2c_uart_cmd_bridge with a UART transmitter model,
//   a hand-driven i2c_control side, and queues holding the expected request
//   and response bytes. Timeouts are shortened through parameter overrides.
module tb_i2c_uart_cmd_bridge;

  localparam int unsigned BT = 40;
  localparam int unsigned IT = 120;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        wrreg_req;
  logic        rdreg_req;
  logic [15:0] addr;
  logic        addr_mode;
  logic [7:0]  wrdata;
  logic [7:0]  device_id;
  logic        RW_Done = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  rddata = '0;
  logic        busy;

  i2c_uart_cmd_bridge #(
    .HEADER      (8'h55),
    .BYTE_TIMEOUT(BT),
    .I2C_TIMEOUT (IT)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .wrreg_req(wrreg_req),
    .rdreg_req(rdreg_req),
    .addr     (addr),
    .addr_mode(addr_mode),
    .wrdata   (wrdata),
    .device_id(device_id),
    .RW_Done  (RW_Done),
    .ack      (ack),
    .rddata   (rddata),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic        mode;
    logic [7:0]  dev;
    logic [7:0]  data;
  } req_t;

  req_t       req_q[$];
  logic [7:0] tx_q[$];
  int         req_seen = 0;
  int         last_rx_cyc = 0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_data"},   32'(tx_data),   32'h0);
    check({tag, "_tx_start"},  32'(tx_start),  32'h0);
    check({tag, "_wrreg_req"}, 32'(wrreg_req), 32'h0);
    check({tag, "_rdreg_req"}, 32'(rdreg_req), 32'h0);
    check({tag, "_addr"},      32'(addr),      32'h0);
    check({tag, "_addr_mode"}, 32'(addr_mode), 32'h0);
    check({tag, "_wrdata"},    32'(wrdata),    32'h0);
    check({tag, "_device_id"}, 32'(device_id), 32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    @(posedge Clk); #1;
    rx_done = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5);
    logic [7:0] f [6];
    f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3; f[4] = b4; f[5] = b5;
    for (int i = 0; i < n; i++) send_byte(f[i]);
  endtask

  task automatic push_req(input logic rd, input logic [15:0] a, input logic m,
                          input logic [7:0] d, input logic [7:0] w);
    req_t e;
    e.rd = rd; e.addr = a; e.mode = m; e.dev = d; e.data = w;
    req_q.push_back(e);
  endtask

  task automatic wait_req(input int start);
    int k = 0;
    while (req_seen == start && k < 60) begin
      @(posedge Clk);
      k++;
    end
    check("req_issued", 32'(req_seen), 32'(start + 1));
  endtask

  task automatic rw_done_pulse(input logic a, input logic [7:0] d);
    @(posedge Clk); #1;
    ack = a; rddata = d; RW_Done = 1'b1;
    @(posedge Clk); #1;
    RW_Done = 1'b0; ack = 1'b0; rddata = '0;
    check("tx_start_after_rw_done", 32'(tx_start), 32'h1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int k = 0;
    while (busy !== 1'b0 && k < max_cycles) begin
      @(posedge Clk);
      k++;
    end
    repeat (8) @(posedge Clk);
    #1;
    check("busy_idle", 32'(busy), 32'h0);
    check("tx_q_drained", 32'(tx_q.size()), 32'h0);
    check("req_q_drained", 32'(req_q.size()), 32'h0);
  endtask

  // Request / response monitor
  initial begin
    req_t e;
    forever begin
      @(negedge Clk);
      if (wrreg_req === 1'b1 || rdreg_req === 1'b1) begin
        req_seen++;
        if (req_q.size() == 0) begin
          check("spurious_req", 32'h1, 32'h0);
        end else begin
          e = req_q.pop_front();
          check("req_kind", 32'({rdreg_req, wrreg_req}), 32'(e.rd ? 2'b10 : 2'b01));
          check("req_addr", 32'(addr), 32'(e.addr));
          check("req_addr_mode", 32'(addr_mode), 32'(e.mode));
          check("req_device_id", 32'(device_id), 32'(e.dev));
          if (!e.rd) check("req_wrdata", 32'(wrdata), 32'(e.data));
          check("req_latency", 32'(cyc), 32'(last_rx_cyc + 1));
        end
      end
      if (tx_start === 1'b1) begin
        if (tx_q.size() == 0) check("spurious_tx", 32'(tx_data), 32'hFFFF);
        else check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  // UART transmitter model: finishes each byte a few cycles after tx_start.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge Clk);
      if (tx_start === 1'b1 && Rst === 1'b0) begin
        b = tx_data;
        repeat (3) @(posedge Clk);
        #1;
        check("tx_data_stable", 32'(tx_data), 32'(b));
        tx_done = 1'b1;
        @(posedge Clk); #1;
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Rst = 1'b0;
    repeat (2) @(posedge Clk);

    // Write, ack=0 -> A5 only
    push_req(1'b0, 16'h000A, 1'b0, 8'hA0, 8'hD1);
    s = req_seen;
    send_frame(6, 8'h55, 8'h00, 8'hA0, 8'h00, 8'h0A, 8'hD1);
    wait_req(s);
    check("busy_in_wait", 32'(busy), 32'h1);
    tx_q.push_back(8'hA5);
    rw_done_pulse(1'b0, 8'h00);
    wait_idle(100);

    // Read, ack=0 -> A5 then data
    push_req(1'b1, 16'h000B, 1'b0, 8'hA0, 8'h00);
    s = req_seen;
    send_frame(5, 8'h55, 8'h01, 8'hA0, 8'h00, 8'h0B, 8'h00);
    wait_req(s);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'hD2);
    rw_done_pulse(1'b0, 8'hD2);
    wait_idle(100);

    // Read 16-bit address, NACK -> EE only
    push_req(1'b1, 16'h1234, 1'b1, 8'hA0, 8'h00);
    s = req_seen;
    send_frame(5, 8'h55, 8'h03, 8'hA0, 8'h12, 8'h34, 8'h00);
    wait_req(s);
    tx_q.push_back(8'hEE);
    rw_done_pulse(1'b1, 8'h77);
    wait_idle(100);

    // RW_Done while idle is ignored
    @(posedge Clk); #1;
    RW_Done = 1'b1;
    @(posedge Clk); #1;
    RW_Done = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("rw_done_idle_busy", 32'(busy), 32'h0);

    // Bad opcode -> E1, then a normal write
    tx_q.push_back(8'hE1);
    send_frame(2, 8'h55, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle(100);
    push_req(1'b0, 16'h0020, 1'b0, 8'h50, 8'h3C);
    s = req_seen;
    send_frame(6, 8'h55, 8'h00, 8'h50, 8'h00, 8'h20, 8'h3C);
    wait_req(s);
    tx_q.push_back(8'hA5);
    rw_done_pulse(1'b0, 8'h00);
    wait_idle(100);

    // Byte timeout mid-frame -> silent abort, then a normal write
    send_frame(3, 8'h55, 8'h00, 8'hA0, 8'h00, 8'h00, 8'h00);
    repeat (BT + 10) @(posedge Clk);
    #1;
    check("byte_timeout_busy", 32'(busy), 32'h0);
    check("byte_timeout_addr_held", 32'(addr), 32'h0020);
    push_req(1'b0, 16'h000C, 1'b0, 8'hA0, 8'hD3);
    s = req_seen;
    send_frame(6, 8'h55, 8'h00, 8'hA0, 8'h00, 8'h0C, 8'hD3);
    wait_req(s);
    tx_q.push_back(8'hA5);
    rw_done_pulse(1'b0, 8'h00);
    wait_idle(100);

    // No RW_Done -> EF
    push_req(1'b1, 16'h000E, 1'b0, 8'hA0, 8'h00);
    s = req_seen;
    send_frame(5, 8'h55, 8'h01, 8'hA0, 8'h00, 8'h0E, 8'h00);
    wait_req(s);
    tx_q.push_back(8'hEF);
    wait_idle(IT + 100);

    // Extra bytes during WAIT_DONE, then reset mid-transaction
    push_req(1'b0, 16'h0044, 1'b0, 8'hA0, 8'h99);
    s = req_seen;
    send_frame(6, 8'h55, 8'h00, 8'hA0, 8'h00, 8'h44, 8'h99);
    wait_req(s);
    send_frame(6, 8'h55, 8'h00, 8'hA0, 8'h00, 8'h45, 8'h9A);
    check("wait_done_busy", 32'(busy), 32'h1);
    Rst = 1'b1;
    #2;
    check_all_zero("async_reset");
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    wait_idle(20);

    // Read after reset
    push_req(1'b1, 16'h000B, 1'b0, 8'hA0, 8'h00);
    s = req_seen;
    send_frame(5, 8'h55, 8'h01, 8'hA0, 8'h00, 8'h0B, 8'h00);
    wait_req(s);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h5A);
    rw_done_pulse(1'b0, 8'h5A);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
